ysyx_23060203_wbu_csr: RTL and testbench

YSYX_23060203_WBU_CSR -- requirements
Module: ysyx_23060203_wbu_csr

---
 rtl/ysyx_23060203_wbu_csr.sv | 200 ++++++++++++++++++++
 tb/tb_ysyx_23060203_wbu_csr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_wbu_csr.sv
// Write-back unit with machine-mode CSR file: commits GPR writes, handles
// ecall/mret/csrw/fence.i redirects and keeps the mcycle/minstret counters.
module ysyx_23060203_wbu_csr (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        icache_inv
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

  localparam logic [31:0] MVENDORID_VAL  = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL    = 32'h015F_DF0B;
  localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mstatus_val;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [63:0] mcycle_next;
  logic [63:0] minstret_next;

  logic        commit;
  logic        do_exc;
  logic        do_ret;
  logic        do_low;
  logic        do_csr;
  logic        do_fence;
  logic [31:0] pc_plus4;

  logic        wr_mstatus;
  logic        wr_mtvec;
  logic        wr_mepc;
  logic        wr_mcause;
  logic        wr_mcycle;
  logic        wr_mcycleh;
  logic        wr_minstret;
  logic        wr_minstreth;

  logic        flush_next;
  logic        icache_inv_next;
  logic [31:0] redirect_next;

  assign in_ready = 1'b1;

  // A commit is dropped entirely while the previous redirect is flushing the pipe.
  assign commit   = in_valid & ~flush & ~reset;
  assign do_exc   = commit & in_exc;
  assign do_ret   = commit & ~in_exc & in_ret;
  assign do_low   = commit & ~in_exc & ~in_ret;
  assign do_csr   = do_low & in_csr_wen;
  assign do_fence = do_low & in_fencei;
  assign pc_plus4 = in_pc + 32'd4;

  assign gpr_wen   = commit & ~in_exc & (in_gpr_waddr != 5'd0);
  assign gpr_waddr = in_gpr_waddr;
  assign gpr_wdata = in_gpr_wdata;

  assign wr_mstatus   = do_csr & (in_csr_waddr == ADDR_MSTATUS);
  assign wr_mtvec     = do_csr & (in_csr_waddr == ADDR_MTVEC);
  assign wr_mepc      = do_csr & (in_csr_waddr == ADDR_MEPC);
  assign wr_mcause    = do_csr & (in_csr_waddr == ADDR_MCAUSE);
  assign wr_mcycle    = do_csr & (in_csr_waddr == ADDR_MCYCLE);
  assign wr_mcycleh   = do_csr & (in_csr_waddr == ADDR_MCYCLEH);
  assign wr_minstret  = do_csr & (in_csr_waddr == ADDR_MINSTRET);
  assign wr_minstreth = do_csr & (in_csr_waddr == ADDR_MINSTRETH);

  // MPP is hardwired to machine mode, so only MIE and MPIE need storage.
  assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};

  always_comb begin
    mcycle_next = mcycle + 64'd1;
    if (wr_mcycle) begin
      mcycle_next = {mcycle[63:32], in_csr_wdata};
    end else if (wr_mcycleh) begin
      mcycle_next = {in_csr_wdata, mcycle[31:0]};
    end
  end

  always_comb begin
    minstret_next = commit ? (minstret + 64'd1) : minstret;
    if (wr_minstret) begin
      minstret_next = {minstret[63:32], in_csr_wdata};
    end else if (wr_minstreth) begin
      minstret_next = {in_csr_wdata, minstret[31:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtvec        <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
      mcycle       <= 64'd0;
      minstret     <= 64'd0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
      if (do_exc) begin
        mepc         <= in_pc;
        mcause       <= CAUSE_ECALL_M;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (do_ret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else begin
        if (wr_mstatus) begin
          mstatus_mie  <= in_csr_wdata[3];
          mstatus_mpie <= in_csr_wdata[7];
        end
        if (wr_mtvec) begin
          mtvec <= in_csr_wdata;
        end
        if (wr_mepc) begin
          mepc <= in_csr_wdata;
        end
        if (wr_mcause) begin
          mcause <= in_csr_wdata;
        end
      end
    end
  end

  // Trap targets use the CSR values before this commit's own update.
  always_comb begin
    flush_next      = do_exc | do_ret | do_csr | do_fence;
    icache_inv_next = do_fence;
    redirect_next   = 32'd0;
    if (do_exc) begin
      redirect_next = mtvec;
    end else if (do_ret) begin
      redirect_next = mepc;
    end else if (do_csr | do_fence) begin
      redirect_next = pc_plus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flush       <= 1'b0;
      icache_inv  <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      flush       <= flush_next;
      icache_inv  <= icache_inv_next;
      redirect_pc <= redirect_next;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      ADDR_MSTATUS:   csr_rdata = mstatus_val;
      ADDR_MTVEC:     csr_rdata = mtvec;
      ADDR_MEPC:      csr_rdata = mepc;
      ADDR_MCAUSE:    csr_rdata = mcause;
      ADDR_MCYCLE:    csr_rdata = mcycle[31:0];
      ADDR_MCYCLEH:   csr_rdata = mcycle[63:32];
      ADDR_MINSTRET:  csr_rdata = minstret[31:0];
      ADDR_MINSTRETH: csr_rdata = minstret[63:32];
      ADDR_MVENDORID: csr_rdata = MVENDORID_VAL;
      ADDR_MARCHID:   csr_rdata = MARCHID_VAL;
      default:        csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu_csr.sv
// Directed bench for the WBU/CSR block: stimulus pushes expected GPR writes and
// redirects into queues, a negedge monitor pops and compares them.
module tb_ysyx_23060203_wbu_csr;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } gpr_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        inv;
  } redir_exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_csr_wen;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc;
  logic        in_ret;
  logic        in_fencei;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        icache_inv;

  int assertCount = 0;
  int failCount   = 0;
  gpr_exp_t   gprQ[$];
  redir_exp_t redirQ[$];
  gpr_exp_t   gprExp;
  redir_exp_t redirExp;

  ysyx_23060203_wbu_csr dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_gpr_waddr (in_gpr_waddr),
    .in_gpr_wdata (in_gpr_wdata),
    .in_csr_wen   (in_csr_wen),
    .in_csr_waddr (in_csr_waddr),
    .in_csr_wdata (in_csr_wdata),
    .in_exc       (in_exc),
    .in_ret       (in_ret),
    .in_fencei    (in_fencei),
    .gpr_wen      (gpr_wen),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .icache_inv   (icache_inv)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkCsr(input string name, input logic [11:0] addr, input logic [31:0] expected);
    csr_raddr = addr;
    #1;
    checkOutput(name, csr_rdata, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [4:0] rd,
                               input logic [31:0] rdData, input logic csrWen, input logic [11:0] csrAddr,
                               input logic [31:0] csrData, input logic exc, input logic ret,
                               input logic fencei);
    @(posedge clock);
    #1;
    in_valid     = valid;
    in_pc        = pc;
    in_gpr_waddr = rd;
    in_gpr_wdata = rdData;
    in_csr_wen   = csrWen;
    in_csr_waddr = csrAddr;
    in_csr_wdata = csrData;
    in_exc       = exc;
    in_ret       = ret;
    in_fencei    = fencei;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expectGpr(input logic [4:0] addr, input logic [31:0] data);
    gprQ.push_back('{addr: addr, data: data});
  endtask

  task automatic expectRedirect(input logic [31:0] pc, input logic inv);
    redirQ.push_back('{pc: pc, inv: inv});
  endtask

  // Monitor: every observed write/redirect must match the oldest expectation.
  always @(negedge clock) begin
    if (gpr_wen) begin
      if (gprQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected gpr write: got x%0d=0x%08h, required none", gpr_waddr, gpr_wdata);
      end else begin
        gprExp = gprQ.pop_front();
        checkOutput("gpr_waddr", {27'd0, gpr_waddr}, {27'd0, gprExp.addr});
        checkOutput("gpr_wdata", gpr_wdata, gprExp.data);
      end
    end
    if (flush) begin
      if (redirQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected flush: got redirect 0x%08h, required no flush", redirect_pc);
      end else begin
        redirExp = redirQ.pop_front();
        checkOutput("redirect_pc", redirect_pc, redirExp.pc);
        checkOutput("icache_inv on flush", {31'd0, icache_inv}, {31'd0, redirExp.inv});
      end
    end else begin
      checkOutput("icache_inv idle", {31'd0, icache_inv}, 32'd0);
    end
  end

  initial begin
    reset        = 1'b1;
    csr_raddr    = 12'd0;
    in_valid     = 1'b0;
    in_pc        = 32'd0;
    in_gpr_waddr = 5'd0;
    in_gpr_wdata = 32'd0;
    in_csr_wen   = 1'b0;
    in_csr_waddr = 12'd0;
    in_csr_wdata = 32'd0;
    in_exc       = 1'b0;
    in_ret       = 1'b0;
    in_fencei    = 1'b0;

    // Commits presented during reset must have no effect at all.
    applyStimulus(1'b1, 32'h40, 5'd1, 32'h11, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("gpr_wen in reset", {31'd0, gpr_wen}, 32'd0);
    applyStimulus(1'b1, 32'h44, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    reset = 1'b0;
    checkOutput("in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush reset", {31'd0, flush}, 32'd0);
    checkOutput("redirect_pc reset", redirect_pc, 32'd0);
    checkCsr("mstatus reset", 12'h300, 32'h0000_1800);
    checkCsr("mtvec reset", 12'h305, 32'd0);
    checkCsr("mepc reset", 12'h341, 32'd0);
    checkCsr("mcause reset", 12'h342, 32'd0);
    checkCsr("minstret reset", 12'hB02, 32'd0);
    checkCsr("minstreth reset", 12'hB82, 32'd0);
    checkCsr("mvendorid", 12'hF11, 32'h7973_7978);
    checkCsr("marchid", 12'hF12, 32'h015F_DF0B);
    checkCsr("unimplemented", 12'h340, 32'd0);

    // Trap setup: mtvec, then mstatus with junk bits that must be masked.
    applyStimulus(1'b1, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 12'h305, 32'h8000_0100, 1'b0, 1'b0, 1'b0);
    expectRedirect(32'h8000_0004, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 32'h8000_0004, 5'd0, 32'd0, 1'b1, 12'h300, 32'hFFFF_FF0F, 1'b0, 1'b0, 1'b0);
    expectRedirect(32'h8000_0008, 1'b0);
    idleCycle();
    checkCsr("mtvec written", 12'h305, 32'h8000_0100);
    checkCsr("mstatus masked", 12'h300, 32'h0000_1808);

    // ecall: rd must not be written even though it is nonzero.
    applyStimulus(1'b1, 32'h8000_0010, 5'd3, 32'hDEAD, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    expectRedirect(32'h8000_0100, 1'b0);
    idleCycle();
    checkCsr("mepc ecall", 12'h341, 32'h8000_0010);
    checkCsr("mcause ecall", 12'h342, 32'd11);
    checkCsr("mstatus ecall", 12'h300, 32'h0000_1880);

    applyStimulus(1'b1, 32'h8000_0100, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    expectRedirect(32'h8000_0010, 1'b0);
    idleCycle();
    checkCsr("mstatus mret", 12'h300, 32'h0000_1888);

    // csrw with GPR write at the top of memory: pc+4 wraps, no same-cycle bypass.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 5'd5, 32'd7, 1'b1, 12'h305, 32'h1234, 1'b0, 1'b0, 1'b0);
    expectGpr(5'd5, 32'd7);
    expectRedirect(32'h0000_0000, 1'b0);
    checkCsr("mtvec no bypass", 12'h305, 32'h8000_0100);
    idleCycle();
    checkCsr("mtvec csrw", 12'h305, 32'h1234);

    // Priority: exc wins over ret and csr write; ret wins over csr write.
    applyStimulus(1'b1, 32'h200, 5'd0, 32'd0, 1'b1, 12'h305, 32'h5555, 1'b1, 1'b1, 1'b0);
    expectRedirect(32'h1234, 1'b0);
    idleCycle();
    checkCsr("mtvec after exc prio", 12'h305, 32'h1234);
    checkCsr("mepc exc prio", 12'h341, 32'h200);
    checkCsr("mstatus exc prio", 12'h300, 32'h0000_1880);
    applyStimulus(1'b1, 32'h300, 5'd0, 32'd0, 1'b1, 12'h341, 32'h9999, 1'b0, 1'b1, 1'b0);
    expectRedirect(32'h200, 1'b0);
    idleCycle();
    checkCsr("mepc after ret prio", 12'h341, 32'h200);
    checkCsr("mstatus ret prio", 12'h300, 32'h0000_1888);

    // minstret write wins over its own increment; the commit during flush is dropped.
    applyStimulus(1'b1, 32'h400, 5'd6, 32'h66, 1'b1, 12'hB02, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    expectGpr(5'd6, 32'h66);
    expectRedirect(32'h404, 1'b0);
    applyStimulus(1'b1, 32'h404, 5'd7, 32'h77, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkCsr("minstret written", 12'hB02, 32'hFFFF_FFFF);
    checkCsr("minstreth before carry", 12'hB82, 32'd0);
    applyStimulus(1'b1, 32'h500, 5'd8, 32'h88, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    expectGpr(5'd8, 32'h88);
    applyStimulus(1'b1, 32'h504, 5'd0, 32'h5, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkCsr("minstret wrap", 12'hB02, 32'd0);
    checkCsr("minstreth carry", 12'hB82, 32'd1);
    idleCycle();
    checkCsr("minstret after x0 commit", 12'hB02, 32'd1);

    // mcycle write wins over the increment, then carries into the high half.
    applyStimulus(1'b1, 32'h600, 5'd0, 32'd0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    expectRedirect(32'h604, 1'b0);
    idleCycle();
    checkCsr("mcycle written", 12'hB00, 32'hFFFF_FFFF);
    checkCsr("mcycleh before carry", 12'hB80, 32'd0);
    idleCycle();
    checkCsr("mcycle wrap", 12'hB00, 32'd0);
    checkCsr("mcycleh carry", 12'hB80, 32'd1);

    applyStimulus(1'b1, 32'h700, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    expectRedirect(32'h1234, 1'b0);
    idleCycle();
    checkCsr("minstret counts exc", 12'hB02, 32'd3);
    checkCsr("mepc second ecall", 12'h341, 32'h700);

    applyStimulus(1'b1, 32'h100, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    expectRedirect(32'h104, 1'b1);
    idleCycle();
    idleCycle();
    checkOutput("flush dropped after one cycle", {31'd0, flush}, 32'd0);

    // Reset during the fence.i redirect cycle; the csrw presented alongside is ignored.
    applyStimulus(1'b1, 32'h100, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    expectRedirect(32'h104, 1'b1);
    applyStimulus(1'b1, 32'h104, 5'd0, 32'd0, 1'b1, 12'h305, 32'hABCD, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    checkOutput("flush after reset", {31'd0, flush}, 32'd0);
    checkOutput("icache_inv after reset", {31'd0, icache_inv}, 32'd0);
    checkOutput("redirect_pc after reset", redirect_pc, 32'd0);
    checkCsr("mtvec after reset", 12'h305, 32'd0);
    checkCsr("minstret after reset", 12'hB02, 32'd0);

    idleCycle();
    idleCycle();
    checkOutput("gpr queue drained", gprQ.size(), 32'd0);
    checkOutput("redirect queue drained", redirQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
